// File: rtl/bcd_stopwatch.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch
//   MM:SS BCD stopwatch (00:00 - 59:59) counting rising edges of a divided
//   square wave that is already synchronous to clk. EDGES_PER_SEC rising edges
//   make one second. A start/stop pulse toggles between RUN and PAUSE (starting
//   from IDLE), and a clear pulse returns to IDLE with everything zeroed.
//
// Ports
//   clk        system clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   tick_in    divided square wave, clk-synchronous
//   btn_ss     start/stop request, one-cycle pulse
//   btn_clr    clear request, one-cycle pulse (beats btn_ss and ticks)
//   sec_ones   BCD seconds units (0-9)
//   sec_tens   BCD seconds tens  (0-5)
//   min_ones   BCD minutes units (0-9)
//   min_tens   BCD minutes tens  (0-5)
//   running    high while in RUN
//   sec_pulse  one-cycle pulse on each seconds increment
//   wrapped    sticky flag, set on 59:59 -> 00:00, cleared only by btn_clr/reset
// -----------------------------------------------------------------------------
module bcd_stopwatch #(
  parameter int unsigned EDGES_PER_SEC = 1000,
  parameter int unsigned PRE_W         = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       running,
  output logic       sec_pulse,
  output logic       wrapped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(EDGES_PER_SEC - 1);

  state_e             state_q,    state_d;
  logic [PRE_W-1:0]   pre_q,      pre_d;
  logic [3:0]         sec_ones_q, sec_ones_d;
  logic [2:0]         sec_tens_q, sec_tens_d;
  logic [3:0]         min_ones_q, min_ones_d;
  logic [2:0]         min_tens_q, min_tens_d;
  logic               running_q,  running_d;
  logic               pulse_q,    pulse_d;
  logic               wrapped_q,  wrapped_d;
  logic               tick_q;
  logic               tick_rise;

  // tick_in is already in the clk domain, so a single delay stage suffices.
  assign tick_rise = tick_in & ~tick_q;

  always_comb begin
    // NOTE: every signal assigned here gets a hold/default value first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    pre_d      = pre_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrapped_d  = wrapped_q;
    pulse_d    = 1'b0;

    if (btn_clr) begin
      state_d    = IDLE;
      pre_d      = '0;
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
      wrapped_d  = 1'b0;
    end else begin
      // The current state decides counting, so a tick coincident with the
      // stop request in RUN is still counted.
      if (state_q == RUN && tick_rise) begin
        if (pre_q == PRE_MAX) begin
          pre_d   = '0;
          pulse_d = 1'b1;
          if (sec_ones_q == 4'd9) begin
            sec_ones_d = 4'd0;
            if (sec_tens_q == 3'd5) begin
              sec_tens_d = 3'd0;
              if (min_ones_q == 4'd9) begin
                min_ones_d = 4'd0;
                if (min_tens_q == 3'd5) begin
                  min_tens_d = 3'd0;
                  wrapped_d  = 1'b1;
                end else begin
                  min_tens_d = min_tens_q + 3'd1;
                end
              end else begin
                min_ones_d = min_ones_q + 4'd1;
              end
            end else begin
              sec_tens_d = sec_tens_q + 3'd1;
            end
          end else begin
            sec_ones_d = sec_ones_q + 4'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      if (btn_ss) begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end

    running_d = (state_d == RUN);
  end

  // NOTE: every register here is a small control/counter flop, so all of them
  // take the async reset; there is no memory array that would need to be left
  // unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
      running_q  <= 1'b0;
      pulse_q    <= 1'b0;
      wrapped_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pre_q      <= pre_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      pulse_q    <= pulse_d;
      wrapped_q  <= wrapped_d;
      tick_q     <= tick_in;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign running   = running_q;
  assign sec_pulse = pulse_q;
  assign wrapped   = wrapped_q;

endmodule
